wave_display_multi: RTL and testbench

// Multi-channel oscilloscope pixel renderer between the sample RAMs and the

---
 rtl/wave_display_multi.sv | 125 ++++++++++++
 tb/tb_wave_display_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_display_multi.sv
// Multi-channel oscilloscope pixel renderer.
// Fetch/compare stage then registered colour stage; latency 2.
module wave_display_multi #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int THICK    = 1,
  parameter int Y_OFFSET = 32,
  parameter logic [24*NUM_CH-1:0] CH_COLOR = 48'hFFFFFF_00FF00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [9*NUM_CH-1:0]          read_address,
  input  logic [SAMPLE_W*NUM_CH-1:0]   read_value,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  logic                       bank;
  logic                       in_win;
  logic [8:0]                 addr;
  logic                       win_d;
  logic [7:0]                 yr_d;
  logic [8:0]                 addr_d;
  logic [8:0]                 addr_dd;
  logic                       first_q;
  logic                       moved;
  logic [NUM_CH-1:0][7:0]     prev_q;
  logic [NUM_CH-1:0][7:0]     last_q;
  logic [NUM_CH-1:0][7:0]     row_c;
  logic [NUM_CH-1:0][7:0]     prev_e;
  logic [NUM_CH-1:0][8:0]     lo;
  logic [NUM_CH-1:0][8:0]     hi;
  logic [NUM_CH-1:0]          hit;
  logic [23:0]                color;
  logic                       unused;

  assign in_win = valid & (x[9] ^ x[8]) & ~y[9];
  assign addr = in_win ? {bank, x[9], x[7:1]} : 9'd0;
  assign read_address = {NUM_CH{addr}};
  assign moved = addr_d != addr_dd;
  assign unused = ^read_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank <= 1'b0;
    end else if (valid && x == 11'd0 && y == 10'd0) begin
      bank <= read_index;
    end
  end

  // 9-bit span bounds: hi needs no clamp since yr never exceeds 255
  always_comb begin
    row_c  = '0;
    prev_e = '0;
    lo     = '0;
    hi     = '0;
    hit    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      row_c[c] = {1'b0, read_value[c*SAMPLE_W+SAMPLE_W-1 -: 7]}
               + 8'(Y_OFFSET);
      prev_e[c] = first_q ? row_c[c]
                : moved   ? last_q[c]
                :           prev_q[c];
      if (prev_e[c] < row_c[c]) begin
        lo[c] = {1'b0, prev_e[c]};
        hi[c] = {1'b0, row_c[c]};
      end else begin
        lo[c] = {1'b0, row_c[c]};
        hi[c] = {1'b0, prev_e[c]};
      end
      lo[c] = (lo[c] >= 9'(THICK)) ? lo[c] - 9'(THICK) : 9'd0;
      hi[c] = hi[c] + 9'(THICK);
      hit[c] = win_d & ch_en[c]
             & ({1'b0, yr_d} >= lo[c])
             & ({1'b0, yr_d} <= hi[c]);
    end
  end

  always_comb begin
    color = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) color = CH_COLOR[c*24 +: 24];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_d   <= 1'b0;
      yr_d    <= '0;
      addr_d  <= '0;
      addr_dd <= '0;
      first_q <= 1'b1;
      prev_q  <= '0;
      last_q  <= '0;
    end else begin
      win_d   <= in_win;
      yr_d    <= y[8:1];
      addr_d  <= addr;
      addr_dd <= addr_d;
      first_q <= ~win_d;
      prev_q  <= prev_e;
      last_q  <= row_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pixel <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      valid_pixel <= win_d;
      {r, g, b}   <= color;
    end
  end

endmodule

// File: tb/tb_wave_display_multi.sv
// Directed table-driven bench for wave_display_multi.
// dut_a: 2 ch, THICK 1, offset 32; dut_b: 1 ch, THICK 3, offset 0.
module tb_wave_display_multi;

  typedef struct {
    logic [10:0] px;
    logic [9:0]  py;
    logic        pv;
    logic [1:0]  en;
    logic        sel;
    logic        chk;
    logic        evp;
    logic [23:0] ergb;
  } vec_t;

  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [1:0]  ch_en;
  logic [17:0] ra_a;
  logic [15:0] rv_a;
  logic        vp_a;
  logic [7:0]  r_a, g_a, b_a;
  logic [8:0]  ra_b;
  logic [7:0]  rv_b;
  logic        vp_b;
  logic [7:0]  r_b, g_b, b_b;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic [7:0] memb [512];

  vec_t tab[$];
  int checks = 0;
  int errors = 0;
  int ys [5] = '{100, 102, 120, 146, 148};
  bit lit[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  wave_display_multi #(
    .NUM_CH(2), .SAMPLE_W(8), .THICK(1), .Y_OFFSET(32),
    .CH_COLOR(48'h00FF00_FF0000)
  ) dut_a (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
    .read_index(read_index), .ch_en(ch_en),
    .read_address(ra_a), .read_value(rv_a),
    .valid_pixel(vp_a), .r(r_a), .g(g_a), .b(b_a)
  );

  wave_display_multi #(
    .NUM_CH(1), .SAMPLE_W(8), .THICK(3), .Y_OFFSET(0),
    .CH_COLOR(24'hFFFFFF)
  ) dut_b (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
    .read_index(read_index), .ch_en(ch_en[0]),
    .read_address(ra_b), .read_value(rv_b),
    .valid_pixel(vp_b), .r(r_b), .g(g_b), .b(b_b)
  );

  always @(posedge clk) begin
    rv_a <= {mem1[ra_a[17:9]], mem0[ra_a[8:0]]};
    rv_b <= memb[ra_b];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [10:0] xi, input logic [9:0] yi,
                      input logic vi, input logic [1:0] en);
    x = xi;
    y = yi;
    valid = vi;
    ch_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int xi, input int yi, input logic vi,
                     input logic [1:0] en, input logic sel,
                     input logic c, input logic evp,
                     input logic [23:0] ergb);
    vec_t e;
    e.px = 11'(xi);
    e.py = 10'(yi);
    e.pv = vi;
    e.en = en;
    e.sel = sel;
    e.chk = c;
    e.evp = evp;
    e.ergb = ergb;
    tab.push_back(e);
  endtask

  task automatic fill(input logic [7:0] v0, input logic [7:0] v1,
                      input logic [7:0] vb);
    for (int i = 0; i < 512; i++) begin
      mem0[i] = v0;
      mem1[i] = v1;
      memb[i] = vb;
    end
  endtask

  // ch_en is seen at the compare stage, one cycle after the pixel's x/y
  task automatic run_tab(input string tag);
    int n;
    n = tab.size();
    for (int i = 0; i <= n; i++) begin
      logic [1:0] en_now;
      if (i == 0) en_now = tab[0].en;
      else en_now = tab[i-1].en;
      if (i < n) step(tab[i].px, tab[i].py, tab[i].pv, en_now);
      else step(tab[n-1].px, tab[n-1].py, 1'b0, en_now);
      if (i > 0 && tab[i-1].chk) begin
        if (tab[i-1].sel) begin
          chk($sformatf("%s%0d_vp", tag, i-1), 32'(vp_b),
              32'(tab[i-1].evp));
          chk($sformatf("%s%0d_rgb", tag, i-1), 32'({r_b, g_b, b_b}),
              32'(tab[i-1].ergb));
        end else begin
          chk($sformatf("%s%0d_vp", tag, i-1), 32'(vp_a),
              32'(tab[i-1].evp));
          chk($sformatf("%s%0d_rgb", tag, i-1), 32'({r_a, g_a, b_a}),
              32'(tab[i-1].ergb));
        end
      end
    end
    tab.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    read_index = 1'b0;
    ch_en = 2'b11;
    valid = 1'b1;
    x = '0;
    y = '0;
    fill(8'd64, 8'd200, 8'd0);

    for (int i = 0; i < 4; i++) begin
      x = 11'($urandom_range(0, 1279));
      y = 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      chk("rst_a", 32'({vp_a, r_a, g_a, b_a}), 32'd0);
      chk("rst_b", 32'({vp_b, r_b, g_b, b_b}), 32'd0);
    end
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    step(300, 128, 1'b1, 2'b11);
    chk("lat1_vp", 32'(vp_a), 32'd0);
    step(300, 128, 1'b1, 2'b11);
    chk("lat2_vp", 32'(vp_a), 32'd1);
    chk("lat2_rgb", 32'({r_a, g_a, b_a}), 32'(RED));

    // ch0 row 64 (63..65), ch1 row 132 (131..133)
    add(300, 128, 1, 2'b11, 0, 1, 1, RED);
    add(300, 126, 1, 2'b11, 0, 1, 1, RED);
    add(300, 124, 1, 2'b11, 0, 1, 1, BLACK);
    add(300, 131, 1, 2'b11, 0, 1, 1, RED);
    add(300, 132, 1, 2'b11, 0, 1, 1, BLACK);
    add(300, 264, 1, 2'b11, 0, 1, 1, GREEN);
    add(300, 262, 1, 2'b10, 0, 1, 1, GREEN);
    add(300, 128, 1, 2'b10, 0, 1, 1, BLACK);
    add(300, 128, 1, 2'b00, 0, 1, 1, BLACK);
    add(300, 128, 1, 2'b01, 0, 1, 1, RED);
    add(255, 128, 1, 2'b11, 0, 1, 0, BLACK);
    add(768, 128, 1, 2'b11, 0, 1, 0, BLACK);
    add(767, 128, 1, 2'b11, 0, 1, 1, RED);
    add(256, 128, 1, 2'b11, 0, 1, 1, RED);
    add(300, 600, 1, 2'b11, 0, 1, 0, BLACK);
    add(300, 128, 0, 2'b11, 0, 1, 0, BLACK);
    add(1100, 128, 1, 2'b11, 0, 1, 0, BLACK);
    add(512, 128, 1, 2'b11, 0, 1, 1, RED);
    run_tab("basic");

    // both channels row 100: priority ch0 over ch1
    fill(8'd136, 8'd136, 8'd0);
    add(400, 200, 0, 2'b11, 0, 0, 0, BLACK);
    add(400, 200, 1, 2'b11, 0, 1, 1, RED);
    add(400, 200, 1, 2'b10, 0, 1, 1, GREEN);
    add(400, 200, 1, 2'b00, 0, 1, 1, BLACK);
    add(400, 200, 1, 2'b01, 0, 1, 1, RED);
    add(400, 196, 1, 2'b11, 0, 1, 1, BLACK);
    add(400, 198, 1, 2'b11, 0, 1, 1, RED);
    add(400, 203, 1, 2'b10, 0, 1, 1, GREEN);
    add(400, 204, 1, 2'b11, 0, 1, 1, BLACK);
    run_tab("prio");

    // sample 22 row 52, sample 23 row 72 -> joined span 51..73
    fill(8'd64, 8'd200, 8'd0);
    mem0[22] = 8'd40;
    mem0[23] = 8'd80;
    for (int k = 0; k < 5; k++) begin
      add(296, ys[k], 0, 2'b01, 0, 0, 0, BLACK);
      for (int xx = 296; xx <= 305; xx++) begin
        add(xx, ys[k], 1, 2'b01, 0, (xx == 302 || xx == 303), 1,
            lit[k] ? RED : BLACK);
      end
    end
    add(296, 120, 0, 2'b01, 0, 0, 0, BLACK);
    for (int xx = 296; xx <= 301; xx++) begin
      add(xx, 120, 1, 2'b01, 0, 0, 0, BLACK);
    end
    add(302, 120, 1, 2'b00, 0, 1, 1, BLACK);
    add(303, 120, 1, 2'b01, 0, 1, 1, RED);
    run_tab("join");

    read_index = 1'b1;
    step(300, 300, 1'b1, 2'b11);
    chk("bank_hold_a", 32'(ra_a), 32'({9'h016, 9'h016}));
    step(300, 300, 1'b1, 2'b11);
    chk("bank_hold_b", 32'(ra_b), 32'(9'h016));
    step(0, 0, 1'b1, 2'b11);
    read_index = 1'b0;
    step(300, 5, 1'b1, 2'b11);
    chk("bank_new_a", 32'(ra_a), 32'({9'h116, 9'h116}));
    chk("bank_new_b", 32'(ra_b), 32'(9'h116));
    step(0, 0, 1'b1, 2'b11);
    step(300, 5, 1'b1, 2'b11);
    chk("bank_back", 32'(ra_a), 32'({9'h016, 9'h016}));

    // dut_b: sample 0 -> rows 0..3; sample 255 row 100 before line
    fill(8'd64, 8'd200, 8'd0);
    memb[255] = 8'd200;
    add(767, 100, 1, 2'b01, 1, 0, 0, BLACK);
    add(767, 100, 0, 2'b01, 1, 1, 0, BLACK);
    add(256, 100, 1, 2'b01, 1, 1, 1, BLACK);
    add(257, 100, 1, 2'b01, 1, 1, 1, BLACK);
    add(258, 100, 1, 2'b01, 1, 1, 1, BLACK);
    add(258, 6, 0, 2'b01, 1, 0, 0, BLACK);
    add(256, 6, 1, 2'b01, 1, 1, 1, WHITE);
    add(256, 8, 1, 2'b01, 1, 1, 1, BLACK);
    add(300, 510, 1, 2'b01, 1, 1, 1, BLACK);
    add(300, 506, 1, 2'b01, 1, 1, 1, BLACK);
    add(300, 0, 1, 2'b01, 1, 1, 1, WHITE);
    add(300, 1, 1, 2'b01, 1, 1, 1, WHITE);
    add(768, 6, 1, 2'b01, 1, 1, 0, BLACK);
    run_tab("sat");

    step(300, 0, 1'b1, 2'b01);
    step(300, 0, 1'b1, 2'b01);
    chk("pre_rst_rgb", 32'({r_b, g_b, b_b}), 32'(WHITE));
    reset = 1'b0;
    #1;
    chk("async_rst_b", 32'({vp_b, r_b, g_b, b_b}), 32'd0);
    chk("async_rst_a", 32'(vp_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
